detector_patron: RTL and testbench
==================================

# detector_patron

Downstream monitor for the single-bit output `z` of `secuencial_01`. It samples `z` on qualified clock edges and detects a parameterised 4-bit serial pattern, with overlapping matches allowed. It counts matches in a saturating counter and measures the length of each high pulse on `z`. All logic is in the `clk` domain and drives status to the board LEDs / 7-segment stage.

## Interface
Parameters:
- `PATTERN`, `4'b1011`, serial pattern; `PATTERN[3]` is the oldest bit, `PATTERN[0]` the newest.
- `CNT_W`, `8`, width of `match_count` and `pulse_len`; legal range 2..16.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  sample qualifier; `z_in` is consumed only on edges where `en`=1.
- `clear`  in  1  synchronous soft clear of counters and history.
- `z_in`  in  1  serial data from `secuencial_01.z`.
- `match`  out  1  one-cycle pulse: pattern completed by the last sample.
- `match_count`  out  `CNT_W`  number of matches, saturating.
- `count_sat`  out  1  sticky: `match_count` has reached all-ones.
- `pulse_len`  out  `CNT_W`  length, in samples, of the last completed high run of `z_in`.
- `pulse_valid`  out  1  one-cycle pulse: `pulse_len` was just updated.

## Operation
- Priority on each edge: `rst` > `clear` > `en` > hold.
- History register `hist[3:0]` plus fill state `fill` ∈ {F0, F1, F2, F3, FULL}.
  - Each sample: `hist <= {hist[2:0], z_in}`.
  - `fill` advances F0→F1→F2→F3→FULL and stays in FULL.
- Match condition on a sample edge: `fill` ∈ {F3, FULL} and `{hist[2:0], z_in} == PATTERN`.
  - Overlap is allowed; history is not flushed on a match.
- On a match: `match_count` increments unless it is all-ones. `count_sat` is set when the count becomes all-ones and stays set until `rst` or `clear`.
- Run counter `run` (`CNT_W` bits, internal):
  - sample with `z_in`=1: `run <= run+1`, saturating at all-ones.
  - sample with `z_in`=0 and `run`≠0: `pulse_len <= run`, `pulse_valid` pulses, `run <= 0`.
  - sample with `z_in`=0 and `run`=0: no event.
- A high run still open when `rst` or `clear` hits is discarded; no `pulse_valid` is produced for it.
- `clear`: zeroes `hist`, `fill`, `run`, `match_count`, `count_sat`, `match`, `pulse_valid`. `pulse_len` keeps its last value. A sample coincident with `clear` is discarded.
- `en`=0: all state holds; `match` and `pulse_valid` are 0.

## Timing
- Reset values: `match`=0, `match_count`=0, `count_sat`=0, `pulse_len`=0, `pulse_valid`=0, `fill`=F0, `hist`=0, `run`=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency:
  - `match` is high in the cycle after the edge that sampled the completing bit.
  - `match_count` updates on that same edge.
- `match` and `pulse_valid` are high for exactly one cycle per event.
  - Back-to-back events on consecutive sampled edges give consecutive high cycles.
- `pulse_valid` and `pulse_len` appear in the cycle after the edge that samples the terminating 0.
- `rst` or `clear` asserted mid-pattern:
  - the partial pattern is lost;
  - a new match needs 4 fresh samples;
  - the earliest possible match is the 4th qualified edge after deassertion.
- `rst` during a `match` cycle: `match` is 0 on the next cycle.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `z_in`=1, `en`=1 → all outputs 0; `match_count` stays 0 throughout.
- **Overlapping matches:** `PATTERN`=1011, `en`=1, `z_in` sequence 1,0,1,1,0,1,1 → `match` pulses one cycle after the 4th and 7th samples. Final `match_count`=2.
- **Enable gating:** sequence 1,0,(`en`=0 for 5 cycles with `z_in` toggling),1,1 → one match after the final sample; no `match` during the gap.
- **Saturation:** `CNT_W`=3, repeat 1011 with no overlap 9 times → `match_count`=7. `count_sat` rises on the 7th match; the 8th and 9th matches pulse `match` but do not change the count.
- **Pulse length:** `z_in` 0,1,1,1,0,0,1,0 → `pulse_valid` one cycle after the 5th sample with `pulse_len`=3, then again after the 8th sample with `pulse_len`=1.
- **Clear mid-operation:** samples 1,0,1, then `clear`=1 coincident with a `z_in`=1 sample, then 1,0,1,1 → no `match` until the 4th post-clear sample. `match_count` goes 0→1, and `pulse_len` keeps its prior value until the next 0 ends a run.

Source files
------------

// File: rtl/detector_patron.sv
// Serial pattern monitor for the z output of secuencial_01: overlapping 4-bit
// pattern match, saturating match counter and high-pulse length measurement.
module detector_patron #(
   parameter logic [3:0] PATTERN = 4'b1011,
   parameter int         CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic             z_in,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat,
   output logic [CNT_W-1:0] pulse_len,
   output logic             pulse_valid
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      F0   = 3'd0,
      F1   = 3'd1,
      F2   = 3'd2,
      F3   = 3'd3,
      FULL = 3'd4
   } fill_t;

   fill_t            fill_r, fill_s;
   logic [3:0]       hist_r, hist_s;
   logic [CNT_W-1:0] run_r, run_s;
   logic [CNT_W-1:0] count_s, plen_s;
   logic             match_s, sat_s, pv_s;
   logic [3:0]       window_s;
   logic             hit_s;

   // The window includes the bit being sampled now, so a match is seen on the completing edge.
   assign window_s = {hist_r[2:0], z_in};
   assign hit_s    = ((fill_r == F3) || (fill_r == FULL)) && (window_s == PATTERN);

   // Next-state and next-output logic; clear outranks the sample qualifier.
   always_comb begin
      fill_s  = fill_r;
      hist_s  = hist_r;
      run_s   = run_r;
      count_s = match_count;
      sat_s   = count_sat;
      plen_s  = pulse_len;
      match_s = 1'b0;
      pv_s    = 1'b0;
      if (clear) begin
         fill_s  = F0;
         hist_s  = 4'b0000;
         run_s   = CNT_ZERO;
         count_s = CNT_ZERO;
         sat_s   = 1'b0;
      end else if (en) begin
         hist_s = window_s;
         case (fill_r)
            F0:      fill_s = F1;
            F1:      fill_s = F2;
            F2:      fill_s = F3;
            F3:      fill_s = FULL;
            FULL:    fill_s = FULL;
            default: fill_s = F0;
         endcase
         if (hit_s) begin
            match_s = 1'b1;
            if (match_count != CNT_MAX) begin
               count_s = match_count + CNT_ONE;
            end else begin
               count_s = match_count;
            end
            if (count_s == CNT_MAX) begin
               sat_s = 1'b1;
            end else begin
               sat_s = count_sat;
            end
         end else begin
            count_s = match_count;
         end
         // A falling sample closes the current high run, if there is one.
         if (z_in) begin
            if (run_r != CNT_MAX) begin
               run_s = run_r + CNT_ONE;
            end else begin
               run_s = run_r;
            end
         end else if (run_r != CNT_ZERO) begin
            plen_s = run_r;
            pv_s   = 1'b1;
            run_s  = CNT_ZERO;
         end else begin
            run_s = run_r;
         end
      end else begin
         fill_s = fill_r;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_r      <= F0;
         hist_r      <= 4'b0000;
         run_r       <= CNT_ZERO;
         match       <= 1'b0;
         match_count <= CNT_ZERO;
         count_sat   <= 1'b0;
         pulse_len   <= CNT_ZERO;
         pulse_valid <= 1'b0;
      end else begin
         fill_r      <= fill_s;
         hist_r      <= hist_s;
         run_r       <= run_s;
         match       <= match_s;
         match_count <= count_s;
         count_sat   <= sat_s;
         pulse_len   <= plen_s;
         pulse_valid <= pv_s;
      end
   end

endmodule

// File: tb/tb_detector_patron.sv
// Scoreboard bench for detector_patron: two instances (CNT_W=8 and CNT_W=3)
// share directed stimulus; a negedge monitor checks every match/pulse event.
module tb_detector_patron;

   logic clk = 1'b0;
   logic rst, en, clear, z_in;

   logic       m8_match, m8_sat, m8_pv;
   logic [7:0] m8_count, m8_len;
   logic       m3_match, m3_sat, m3_pv;
   logic [2:0] m3_count, m3_len;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int e8     = 0;
   int e3     = 0;
   bit es3    = 1'b0;

   typedef struct {
      int cyc;
      int c8;
      int c3;
      bit s3;
   } mexp_t;

   typedef struct {
      int cyc;
      int len;
   } pexp_t;

   mexp_t mq[$];
   pexp_t pq[$];

   detector_patron #(.PATTERN(4'b1011), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .z_in(z_in),
      .match(m8_match), .match_count(m8_count), .count_sat(m8_sat),
      .pulse_len(m8_len), .pulse_valid(m8_pv)
   );

   detector_patron #(.PATTERN(4'b1011), .CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .z_in(z_in),
      .match(m3_match), .match_count(m3_count), .count_sat(m3_sat),
      .pulse_len(m3_len), .pulse_valid(m3_pv)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every event the DUTs present must match the front of its queue.
   always @(negedge clk) begin
      mexp_t me;
      pexp_t pe;
      while (mq.size() > 0 && mq[0].cyc < cyc) begin
         n_chk++;
         n_fail++;
         $display("FAIL match_missing: required match in cycle %0d did not occur", mq[0].cyc);
         void'(mq.pop_front());
      end
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
         n_chk++;
         n_fail++;
         $display("FAIL pulse_missing: required pulse_valid in cycle %0d did not occur", pq[0].cyc);
         void'(pq.pop_front());
      end
      if (m8_match || m3_match) begin
         n_chk++;
         if (mq.size() == 0 || mq[0].cyc != cyc) begin
            n_fail++;
            $display("FAIL match_unexpected: cycle %0d m8=%0b m3=%0b, required no match", cyc, m8_match, m3_match);
         end else begin
            me = mq.pop_front();
            if (!(m8_match && m3_match) || m8_count != 8'(me.c8) || m3_count != 3'(me.c3)
                || m3_sat != me.s3 || m8_sat != 1'b0) begin
               n_fail++;
               $display("FAIL match_event: cycle %0d got m=%0b/%0b cnt=%0d/%0d sat=%0b/%0b, required m=1/1 cnt=%0d/%0d sat=0/%0b",
                        cyc, m8_match, m3_match, m8_count, m3_count, m8_sat, m3_sat, me.c8, me.c3, me.s3);
            end
         end
      end
      if (m8_pv || m3_pv) begin
         n_chk++;
         if (pq.size() == 0 || pq[0].cyc != cyc) begin
            n_fail++;
            $display("FAIL pulse_unexpected: cycle %0d pv=%0b/%0b len=%0d, required no pulse", cyc, m8_pv, m3_pv, m8_len);
         end else begin
            pe = pq.pop_front();
            if (!(m8_pv && m3_pv) || m8_len != 8'(pe.len) || m3_len != 3'(pe.len)) begin
               n_fail++;
               $display("FAIL pulse_event: cycle %0d got pv=%0b/%0b len=%0d/%0d, required pv=1/1 len=%0d",
                        cyc, m8_pv, m3_pv, m8_len, m3_len, pe.len);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {4'b0000, m8_match, m8_count, m8_sat, m8_len, m8_pv,
              m3_match, m3_count, m3_sat, m3_len, m3_pv};
   endfunction

   // One qualified sample; m marks an expected match, plen>0 an expected pulse.
   task automatic smp(input logic z, input bit m, input int plen);
      @(negedge clk);
      rst = 1'b0; clear = 1'b0; en = 1'b1; z_in = z;
      if (m) begin
         e8 = (e8 == 255) ? 255 : e8 + 1;
         e3 = (e3 == 7) ? 7 : e3 + 1;
         if (e3 == 7) es3 = 1'b1;
         mq.push_back('{cyc + 1, e8, e3, es3});
      end
      if (plen != 0) pq.push_back('{cyc + 1, plen});
   endtask

   task automatic gap(input logic z);
      @(negedge clk);
      rst = 1'b0; clear = 1'b0; en = 1'b0; z_in = z;
   endtask

   task automatic clr(input logic z);
      @(negedge clk);
      rst = 1'b0; clear = 1'b1; en = 1'b1; z_in = z;
      e8 = 0; e3 = 0; es3 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; clear = 1'b0; z_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_outputs", all_outs(), 32'd0);
      end

      // Overlapping matches: 1,0,1,1,0,1,1
      clr(1'b0);
      smp(1'b1, 1'b0, 0); smp(1'b0, 1'b0, 1); smp(1'b1, 1'b0, 0); smp(1'b1, 1'b1, 0);
      smp(1'b0, 1'b0, 2); smp(1'b1, 1'b0, 0); smp(1'b1, 1'b1, 0);
      @(negedge clk);
      chk("overlap_final_count", {24'd0, m8_count}, 32'd2);

      // Enable gating: 1,0, five disabled cycles, 1,1
      clr(1'b0);
      smp(1'b1, 1'b0, 0); smp(1'b0, 1'b0, 1);
      gap(1'b1); gap(1'b0); gap(1'b1); gap(1'b0); gap(1'b1);
      smp(1'b1, 1'b0, 0); smp(1'b1, 1'b1, 0);

      // Pulse length: 0,1,1,1,0,0,1,0
      clr(1'b0);
      smp(1'b0, 1'b0, 0); smp(1'b1, 1'b0, 0); smp(1'b1, 1'b0, 0); smp(1'b1, 1'b0, 0);
      smp(1'b0, 1'b0, 3); smp(1'b0, 1'b0, 0); smp(1'b1, 1'b0, 0); smp(1'b0, 1'b0, 1);

      // Clear mid-pattern with a coincident 1 sample, then 1,0,1,1
      smp(1'b1, 1'b0, 0); smp(1'b0, 1'b0, 1); smp(1'b1, 1'b0, 0);
      clr(1'b1);
      @(negedge clk);
      chk("clear_count_zero", {24'd0, m8_count}, 32'd0);
      chk("clear_keeps_pulse_len", {24'd0, m8_len}, 32'd1);
      en = 1'b0; clear = 1'b0;
      smp(1'b1, 1'b0, 0); smp(1'b0, 1'b0, 1); smp(1'b1, 1'b0, 0); smp(1'b1, 1'b1, 0);

      // Saturation: nine non-overlapping 1011 groups
      clr(1'b0);
      for (int i = 0; i < 9; i++) begin
         smp(1'b1, 1'b0, 0);
         smp(1'b0, 1'b0, (i == 0) ? 1 : 3);
         smp(1'b1, 1'b0, 0);
         smp(1'b1, 1'b1, 0);
      end
      @(negedge clk);
      chk("sat_count8", {24'd0, m8_count}, 32'd9);
      chk("sat_count3", {29'd0, m3_count}, 32'd7);
      chk("sat_flag3", {31'd0, m3_sat}, 32'd1);

      // Reset landing on a match cycle, then a fresh match needs 4 samples
      clr(1'b0);
      smp(1'b1, 1'b0, 0); smp(1'b0, 1'b0, 1); smp(1'b1, 1'b0, 0); smp(1'b1, 1'b1, 0);
      @(negedge clk);
      rst = 1'b1; en = 1'b1; z_in = 1'b1;
      e8 = 0; e3 = 0; es3 = 1'b0;
      @(negedge clk);
      chk("rst_on_match_cycle", all_outs(), 32'd0);
      smp(1'b1, 1'b0, 0); smp(1'b0, 1'b0, 1); smp(1'b1, 1'b0, 0); smp(1'b1, 1'b1, 0);

      gap(1'b0);
      gap(1'b0);
      @(negedge clk);
      chk("scoreboard_drained", 32'(mq.size() + pq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
